// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the tx_uart arbiter: FSM state encoding and datapath widths.
package uart_tx_arbiter_pkg;

  localparam int DIV_W  = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker, first set req bit scanning last+1, last+2, ... with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; any=0 when no request is pending.
module uart_tx_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [IDX_W-1:0]   pick
);

  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the nearest requester after last is written last and wins.
  always_comb begin
    any  = |req;
    pick = '0;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one tx_uart among NUM_REQ requesters, one byte per grant, divisor latched per byte.
// Latency: req_valid -> uart_valid 1 clk; uart_ready -> req_ack 1 clk; 3 clk overhead per byte.
// Backpressure: requesters hold req_valid until req_ack; uart_valid held until tx_uart ready pulse.
// Optional: define UART_ARB_LOCK_EN to let a requester holding req_lock keep the grant for its next byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic [DIV_W-1:0]          cfg_div,
  output logic                      uart_valid,
  output logic [DATA_W-1:0]         uart_data,
  output logic [DIV_W-1:0]          uart_div,
  input  logic                      uart_ready,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               valid_d;
  logic [DATA_W-1:0]  data_d;
  logic [DIV_W-1:0]   div_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [IDX_W-1:0]   grant_d;
  logic               any;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   sel;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last_q),
    .any  (any),
    .pick (pick)
  );

`ifdef UART_ARB_LOCK_EN
  // A locked, still-valid last owner skips rotation so its message stays contiguous.
  always_comb begin
    sel = pick;
    if (req_valid[last_q] && req_lock[last_q]) begin
      sel = last_q;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  always_comb begin
    sel = pick;
  end
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    valid_d = uart_valid;
    data_d  = uart_data;
    div_d   = uart_div;
    ack_d   = req_ack;
    grant_d = grant_idx;
    case (state_q)
      IDLE: begin
        if (any) begin
          grant_d = sel;
          data_d  = req_data[DATA_W*sel +: DATA_W];
          div_d   = cfg_div;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Dropping valid on the ready edge keeps tx_uart from seeing a second start.
        if (uart_ready) begin
          valid_d           = 1'b0;
          ack_d             = '0;
          ack_d[grant_idx]  = 1'b1;
          last_d            = grant_idx;
          state_d           = DONE;
        end
      end
      DONE: begin
        ack_d   = '0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        ack_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      uart_valid <= 1'b0;
      uart_data  <= '0;
      uart_div   <= '0;
      req_ack    <= '0;
      grant_idx  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      uart_valid <= valid_d;
      uart_data  <= data_d;
      uart_div   <= div_d;
      req_ack    <= ack_d;
      grant_idx  <= grant_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
